// File: rtl/button_event_arbiter.sv
// Debounced multi-button short/long press detector with a round-robin event output.
// Define BUTTON_REPEAT_EN to emit repeated long events while a long press is held.
module button_event_arbiter #(
    parameter int N_BTN        = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 4,
    parameter int DEB_CYC      = 1_000_000,
    parameter int LONG_TICKS   = 12,
    parameter int REPEAT_TICKS = 2
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic [N_BTN-1:0]           button,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(N_BTN)-1:0]   evt_id,
    output logic                       evt_long,
    output logic                       ovf
);
    localparam int ID_W  = $clog2(N_BTN);
    localparam int CNT_W = $clog2(LONG_TICKS + 1);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [1:0] S_WAIT_REL  = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_LONG_DONE = 2'd3;

    logic [N_BTN-1:0]   sync_p0, sync_p1, deb;
    logic [DEB_W-1:0]   deb_cnt [N_BTN];
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [1:0]         state [N_BTN];
    logic [CNT_W-1:0]   tick_cnt [N_BTN];
`ifdef BUTTON_REPEAT_EN
    localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    logic [REP_W-1:0]   rep_cnt [N_BTN];
`endif
    logic [N_BTN-1:0]   post, post_long, slot_vld, slot_long, acc, busy, avail;
    logic [2*N_BTN-1:0] dbl;
    logic [ID_W-1:0]    ptr, gnt_off, gnt_id, ptr_nxt;
    logic [ID_W:0]      gnt_sum, nxt_sum;
    logic               gnt_any, load;

    // Debounced level resets high so a button held through reset must be seen released first.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '1;
            for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0 <= button;
            sync_p1 <= sync_p0;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                    deb[i]     <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk_in) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + 1'b1;
    end

    always_comb begin
        post      = '0;
        post_long = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (state[i])
                S_HELD: begin
                    if (!deb[i]) begin
                        post[i] = 1'b1;
                    end else if (tick && tick_cnt[i] == CNT_W'(LONG_TICKS - 1)) begin
                        post[i]      = 1'b1;
                        post_long[i] = 1'b1;
                    end
                end
`ifdef BUTTON_REPEAT_EN
                S_LONG_DONE: begin
                    if (deb[i] && tick && rep_cnt[i] == REP_W'(REPEAT_TICKS - 1)) begin
                        post[i]      = 1'b1;
                        post_long[i] = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst) begin
                state[i]    <= S_WAIT_REL;
                tick_cnt[i] <= '0;
`ifdef BUTTON_REPEAT_EN
                rep_cnt[i]  <= '0;
`endif
            end else begin
                case (state[i])
                    S_WAIT_REL: if (!deb[i]) state[i] <= S_IDLE;
                    S_IDLE: begin
                        if (deb[i]) begin
                            state[i]    <= S_HELD;
                            tick_cnt[i] <= '0;
                        end
                    end
                    S_HELD: begin
                        if (!deb[i]) begin
                            state[i] <= S_IDLE;
                        end else if (tick) begin
                            if (post_long[i]) begin
                                state[i]    <= S_LONG_DONE;
                                tick_cnt[i] <= CNT_W'(LONG_TICKS);
`ifdef BUTTON_REPEAT_EN
                                rep_cnt[i]  <= '0;
`endif
                            end else begin
                                tick_cnt[i] <= tick_cnt[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (!deb[i]) begin
                            state[i] <= S_IDLE;
                        end
`ifdef BUTTON_REPEAT_EN
                        else if (tick) begin
                            rep_cnt[i] <= post[i] ? '0 : rep_cnt[i] + 1'b1;
                        end
`endif
                    end
                endcase
            end
        end
    end

    // The slot shown on the output stays occupied until consumed, so it is masked from the arbiter.
    always_comb begin
        busy = '0;
        if (evt_valid) busy[evt_id] = 1'b1;
    end

    assign avail = slot_vld & ~busy;
    assign dbl   = {avail, avail} >> ptr;
    assign load  = !evt_valid || evt_ready;

    always_comb begin
        gnt_any = 1'b0;
        gnt_off = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                gnt_any = 1'b1;
                gnt_off = ID_W'(k);
            end
        end
        gnt_sum = {1'b0, ptr} + {1'b0, gnt_off};
        gnt_id  = (gnt_sum >= (ID_W+1)'(N_BTN)) ? ID_W'(gnt_sum - (ID_W+1)'(N_BTN))
                                                 : gnt_sum[ID_W-1:0];
        nxt_sum = {1'b0, gnt_id} + 1'b1;
        ptr_nxt = (nxt_sum == (ID_W+1)'(N_BTN)) ? '0 : nxt_sum[ID_W-1:0];
        for (int i = 0; i < N_BTN; i++) begin
            acc[i] = evt_valid && evt_ready && (evt_id == ID_W'(i));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            slot_vld  <= '0;
            ovf       <= 1'b0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_long  <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (post[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_long[i] <= post_long[i];
                    if (slot_vld[i] && !acc[i]) ovf <= 1'b1;
                end else if (acc[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
            if (load) begin
                evt_valid <= gnt_any;
                if (gnt_any) begin
                    evt_id   <= gnt_id;
                    evt_long <= slot_long[gnt_id];
                    ptr      <= ptr_nxt;
                end
            end
        end
    end
endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of button inputs (2..8).
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency.
REQ-003 SHALL have parameter TICK_HZ, default 4, press-timing tick rate.
REQ-004 SHALL have parameter DEB_CYC, default 1_000_000, debounce stability window in clk_in cycles.
REQ-005 SHALL have parameter LONG_TICKS, default 12, ticks held to classify a long press (3 s at 4 Hz).
REQ-006 SHALL have parameter REPEAT_TICKS, default 2, auto-repeat interval in ticks (used only with REQ-027).
REQ-007 SHALL have port clk_in, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port button, input, N_BTN, raw asynchronous buttons, 1 = pressed.
REQ-010 SHALL have port evt_valid, output, 1, event available.
REQ-011 SHALL have port evt_ready, input, 1, consumer accepts event.
REQ-012 SHALL have port evt_id, output, clog2(N_BTN), index of button that produced the event.
REQ-013 SHALL have port evt_long, output, 1, 1 = long press, 0 = short press.
REQ-014 SHALL have port ovf, output, 1, sticky flag: a pending event was overwritten.

Function
REQ-015 SHALL synchronise each button bit through two flops; debounced level changes only after DEB_CYC consecutive identical synchronised samples.
REQ-016 SHALL generate a single-cycle tick every CLK_HZ/TICK_HZ cycles from one free-running divider shared by all buttons.
REQ-017 SHALL run per-button FSM IDLE -> HELD on debounced rise, clearing the tick counter (saturating, width clog2(LONG_TICKS+1)).
REQ-018 In HELD, on debounced fall with count < LONG_TICKS: SHALL post a short event and return to IDLE.
REQ-019 In HELD, on the tick making count == LONG_TICKS: SHALL post a long event and go to LONG_DONE; no event on subsequent release; LONG_DONE -> IDLE on debounced fall.
REQ-020 Each button SHALL hold one pending event slot (valid + long bit); posting while the slot is full SHALL overwrite it and set ovf.
REQ-021 The arbiter SHALL select among pending slots round-robin, starting after the last granted index, and load the output register only when evt_valid is 0 or evt_valid & evt_ready.
REQ-022 Latency: event posted in cycle N with an empty output SHALL drive evt_valid in cycle N+2 (slot in N+1, output register in N+2).
REQ-023 evt_valid, evt_id and evt_long SHALL stay stable while evt_valid & !evt_ready; the event is consumed on evt_valid & evt_ready.
REQ-024 Accept of a slot and a new post to the same slot in one cycle SHALL leave the new event pending, without setting ovf.

Reset
REQ-025 On rst: evt_valid=0, evt_id=0, evt_long=0, ovf=0, all slots empty, divider and counters 0, round-robin pointer 0.
REQ-026 After rst, all FSMs SHALL enter a WAIT_REL state and go to IDLE only after the debounced level is 0, so a button held through reset generates no event.

Configuration
REQ-027 Macro BUTTON_REPEAT_EN defined: in LONG_DONE, every REPEAT_TICKS ticks while still held, the block SHALL post another long event; undefined: exactly one long event per hold and REPEAT_TICKS unused.

Verification (CLK_HZ=100, TICK_HZ=4, DEB_CYC=4, LONG_TICKS=12, N_BTN=4)
REQ-028 Press button[1] for 100 cycles, evt_ready=1 -> exactly one event, evt_id=1, evt_long=0, shortly after release.
REQ-029 Hold button[2] for 400 cycles -> one event, evt_id=2, evt_long=1, about 300 cycles after press; none at release (macro off); with macro, further long events every 50 cycles while held.
REQ-030 Release buttons 0 and 3 in the same cycle after short presses, evt_ready=1 -> two events, ids 0 then 3, each one cycle wide.
REQ-031 evt_ready=0; press/release button[0] twice -> ovf=1, one event pending; raise evt_ready -> single event id=0, evt_valid low next cycle.
REQ-032 Bounce button[1] with 3-cycle pulses -> no event; hold button[1] across rst, release, press 50 cycles -> only one short event, after the post-reset press.
